// File: rtl/store_byte_serializer_pkg.sv
// Shared definitions for the store byte serializer: size codes, FSM states
// and per-size lookups used when a store request is accepted.
package store_byte_serializer_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_t;

   // Number of bytes a request of the given size writes (0 for the illegal code).
   function automatic logic [2:0] size_nbytes(input logic [1:0] size);
      logic [2:0] n;
      case (size)
         SZ_BYTE: n = 3'd1;
         SZ_HALF: n = 3'd2;
         SZ_WORD: n = 3'd4;
         default: n = 3'd0;
      endcase
      return n;
   endfunction

   // Size code is defined and the address is naturally aligned for it.
   function automatic logic size_legal(input logic [1:0] size, input logic [1:0] addr_lo);
      logic ok;
      case (size)
         SZ_BYTE: ok = 1'b1;
         SZ_HALF: ok = (addr_lo[0] == 1'b0);
         SZ_WORD: ok = (addr_lo == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/store_byte_serializer_sel.sv
// Little-endian byte lane mux: picks byte idx out of a 32-bit word.
// Kept separate so a load-side assembler can reuse the same lane ordering.
module store_byte_sel (
   input  logic [31:0] data,
   input  logic [1:0]  idx,
   output logic [7:0]  lane
);

   // Select the addressed byte lane.
   always_comb begin
      lane = 8'h00;
      case (idx)
         2'd0:    lane = data[7:0];
         2'd1:    lane = data[15:8];
         2'd2:    lane = data[23:16];
         2'd3:    lane = data[31:24];
         default: lane = 8'h00;
      endcase
   end

endmodule

// File: rtl/store_byte_serializer.sv
// Store-path narrowing unit: turns one byte/half/word store into a sequence
// of little-endian byte writes on a ready/valid byte RAM port, with
// single-cycle done/err pulses and an optional per-byte stall timeout.
module store_byte_serializer
   import store_byte_serializer_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int STALL_LIMIT = 15
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_data,
   input  logic [1:0]        req_size,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_ready,
   output logic              done,
   output logic              err
);

   // Wide enough to hold STALL_LIMIT; at least one bit when the timeout is off.
   localparam int CNT_W = $clog2(STALL_LIMIT + 2);

   state_t            state_r;
   logic [31:0]       data_r;
   logic [1:0]        idx_r;
   logic [1:0]        last_r;
   logic [CNT_W-1:0]  stall_cnt_r;
   logic              req_ready_r;
   logic              mem_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [7:0]        mem_wdata_r;
   logic              done_r;
   logic              err_r;

   logic [31:0]       sel_data_s;
   logic [1:0]        sel_idx_s;
   logic [7:0]        sel_byte_s;
   logic [1:0]        req_last_s;
   logic              stall_hit_s;

   // Byte to present next: byte 0 of the incoming request while idle,
   // otherwise the byte after the one currently on the bus.
   always_comb begin
      sel_data_s = 32'h0000_0000;
      sel_idx_s  = 2'd0;
      if (state_r == ST_IDLE) begin
         sel_data_s = req_data;
         sel_idx_s  = 2'd0;
      end else begin
         sel_data_s = data_r;
         sel_idx_s  = idx_r + 2'd1;
      end
   end

   store_byte_sel u_sel (
      .data (sel_data_s),
      .idx  (sel_idx_s),
      .lane (sel_byte_s)
   );

   // Index of the final byte and the stall-abort condition for this cycle.
   always_comb begin
      req_last_s  = 2'(size_nbytes(req_size) - 3'd1);
      stall_hit_s = 1'b0;
      if (STALL_LIMIT != 0) begin
         stall_hit_s = (stall_cnt_r == CNT_W'(STALL_LIMIT - 1));
      end else begin
         stall_hit_s = 1'b0;
      end
   end

   // Control FSM; all outputs are registered here.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_r     <= ST_IDLE;
         data_r      <= 32'h0000_0000;
         idx_r       <= 2'd0;
         last_r      <= 2'd0;
         stall_cnt_r <= '0;
         req_ready_r <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= 8'h00;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         done_r <= 1'b0;
         err_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               req_ready_r <= 1'b1;
               if (req_valid && req_ready_r) begin
                  if (size_legal(req_size, req_addr[1:0])) begin
                     state_r     <= ST_WRITE;
                     req_ready_r <= 1'b0;
                     data_r      <= req_data;
                     idx_r       <= 2'd0;
                     last_r      <= req_last_s;
                     stall_cnt_r <= '0;
                     mem_we_r    <= 1'b1;
                     mem_addr_r  <= req_addr;
                     mem_wdata_r <= sel_byte_s;
                  end else begin
                     err_r <= 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               if (mem_ready) begin
                  stall_cnt_r <= '0;
                  if (idx_r == last_r) begin
                     state_r     <= ST_IDLE;
                     req_ready_r <= 1'b1;
                     mem_we_r    <= 1'b0;
                     done_r      <= 1'b1;
                  end else begin
                     idx_r       <= idx_r + 2'd1;
                     mem_addr_r  <= mem_addr_r + ADDR_W'(1);
                     mem_wdata_r <= sel_byte_s;
                  end
               end else if (stall_hit_s) begin
                  // Abandon the rest of the store; bytes already taken stay written.
                  state_r     <= ST_IDLE;
                  req_ready_r <= 1'b1;
                  mem_we_r    <= 1'b0;
                  stall_cnt_r <= '0;
                  err_r       <= 1'b1;
               end else begin
                  stall_cnt_r <= stall_cnt_r + CNT_W'(1);
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               req_ready_r <= 1'b1;
               mem_we_r    <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = req_ready_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign done      = done_r;
   assign err       = err_r;

endmodule
